// File: rtl/apple_placer.sv
// apple_placer: picks a free cell on the board for the next apple.
// Random (x,y) samples are tried first. After MAX_TRIES occupied samples
// the search switches to a row-major sweep. The one-hot apple grid is
// then held until the detector reports that the apple was eaten. When
// every cell is occupied the sticky board_full flag is raised instead.
module apple_placer #(
    parameter int GRID      = 16,
    parameter int MAX_TRIES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GRID-1:0][GRID-1:0] lights,
    input  logic [3:0]                rand_x,
    input  logic [3:0]                rand_y,
    input  logic                      eaten,
    output logic [GRID-1:0][GRID-1:0] apple,
    output logic [3:0]                apple_x,
    output logic [3:0]                apple_y,
    output logic                      apple_valid,
    output logic                      board_full
);

    typedef enum logic [2:0] {
        ST_SAMPLE,
        ST_CHECK,
        ST_SCAN,
        ST_HOLD,
        ST_FULL
    } state_t;

    localparam logic [3:0] LP_LAST_TRY  = 4'(MAX_TRIES - 1);
    localparam logic [7:0] LP_LAST_CELL = 8'(GRID * GRID - 1);

    state_t                    r_state;
    logic [3:0]                r_try_cnt;
    logic [7:0]                r_scan_cnt;
    logic [3:0]                r_cand_x;
    logic [3:0]                r_cand_y;
    logic [GRID-1:0][GRID-1:0] r_apple;
    logic [3:0]                r_apple_x;
    logic [3:0]                r_apple_y;
    logic                      r_apple_valid;
    logic                      r_board_full;

    logic                      w_cand_free;
    logic [3:0]                w_next_x;
    logic [3:0]                w_next_y;
    logic [GRID-1:0][GRID-1:0] w_onehot;

    // Occupancy is read live from the snake, so a cell vacated or filled
    // this very cycle is judged on its current value.
    assign w_cand_free = ~lights[r_cand_y][r_cand_x];

    // Row-major successor of the candidate; 4-bit arithmetic gives the
    // (15,15) -> (0,0) wrap for free.
    assign w_next_x = r_cand_x + 4'd1;
    assign w_next_y = (r_cand_x == 4'd15) ? (r_cand_y + 4'd1) : r_cand_y;

    // One-hot image of the candidate cell, loaded into the apple grid on commit.
    always_comb begin
        w_onehot = '0;
        w_onehot[r_cand_y][r_cand_x] = 1'b1;
    end

    // Placement FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_SAMPLE;
            r_try_cnt     <= 4'd0;
            r_scan_cnt    <= 8'd0;
            r_cand_x      <= 4'd0;
            r_cand_y      <= 4'd0;
            r_apple       <= '0;
            r_apple_x     <= 4'd0;
            r_apple_y     <= 4'd0;
            r_apple_valid <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            case (r_state)
                ST_SAMPLE: begin
                    r_cand_x <= rand_x;
                    r_cand_y <= rand_y;
                    r_state  <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (w_cand_free) begin
                        r_apple       <= w_onehot;
                        r_apple_x     <= r_cand_x;
                        r_apple_y     <= r_cand_y;
                        r_apple_valid <= 1'b1;
                        r_try_cnt     <= 4'd0;
                        r_state       <= ST_HOLD;
                    end else if (r_try_cnt == LP_LAST_TRY) begin
                        // Random sampling is not converging; sweep from the
                        // cell after the last rejected sample.
                        r_cand_x   <= w_next_x;
                        r_cand_y   <= w_next_y;
                        r_scan_cnt <= 8'd0;
                        r_state    <= ST_SCAN;
                    end else begin
                        r_try_cnt <= r_try_cnt + 4'd1;
                        r_state   <= ST_SAMPLE;
                    end
                end

                ST_SCAN: begin
                    if (w_cand_free) begin
                        r_apple       <= w_onehot;
                        r_apple_x     <= r_cand_x;
                        r_apple_y     <= r_cand_y;
                        r_apple_valid <= 1'b1;
                        r_try_cnt     <= 4'd0;
                        r_state       <= ST_HOLD;
                    end else if (r_scan_cnt == LP_LAST_CELL) begin
                        // Every cell has been visited once and all were occupied.
                        r_board_full  <= 1'b1;
                        r_apple       <= '0;
                        r_apple_valid <= 1'b0;
                        r_state       <= ST_FULL;
                    end else begin
                        r_cand_x   <= w_next_x;
                        r_cand_y   <= w_next_y;
                        r_scan_cnt <= r_scan_cnt + 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (eaten) begin
                        // Coordinates are left stale; apple_valid marks them unused.
                        r_apple       <= '0;
                        r_apple_valid <= 1'b0;
                        r_try_cnt     <= 4'd0;
                        r_state       <= ST_SAMPLE;
                    end
                end

                ST_FULL: begin
                    // Terminal until reset; eaten has no meaning here.
                    r_state <= ST_FULL;
                end

                default: begin
                    r_state <= ST_SAMPLE;
                end
            endcase
        end
    end

    assign apple       = r_apple;
    assign apple_x     = r_apple_x;
    assign apple_y     = r_apple_y;
    assign apple_valid = r_apple_valid;
    assign board_full  = r_board_full;

endmodule

// File: tb/tb_apple_placer.sv
// Testbench for apple_placer: directed scenarios, a procedural reference
// model of the placement search, and a per-cycle output comparison.
module tb_apple_placer;

    localparam int MAX_TRIES = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0][15:0] lights;
    logic [3:0]       rand_x;
    logic [3:0]       rand_y;
    logic             eaten;
    logic [15:0][15:0] apple;
    logic [3:0]       apple_x;
    logic [3:0]       apple_y;
    logic             apple_valid;
    logic             board_full;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apple_placer #(
        .GRID      (16),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lights      (lights),
        .rand_x      (rand_x),
        .rand_y      (rand_y),
        .eaten       (eaten),
        .apple       (apple),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .board_full  (board_full)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs as seen at the most recent rising edge.
    logic              s_rst;
    logic              s_e;
    logic [3:0]        s_rx;
    logic [3:0]        s_ry;
    logic [15:0][15:0] s_lt;

    bit m_armed = 1'b0;
    bit m_valid;
    bit m_full;
    int m_x;
    int m_y;

    task automatic step();
        @(posedge clk);
        s_rst = reset;
        s_e   = eaten;
        s_rx  = rand_x;
        s_ry  = rand_y;
        s_lt  = lights;
    endtask

    initial begin : model
        bit placed;
        bit aborted;
        int cx;
        int cy;
        int base;
        int c;
        m_valid = 1'b0;
        m_full  = 1'b0;
        m_x     = 0;
        m_y     = 0;
        do step(); while (s_rst !== 1'b1);
        m_armed = 1'b1;
        forever begin
            placed  = 1'b0;
            aborted = 1'b0;
            cx      = 0;
            cy      = 0;
            // random phase: one edge to take a sample, one edge to judge it
            for (int t = 0; t < MAX_TRIES; t++) begin
                step();
                if (s_rst) begin aborted = 1'b1; break; end
                cx = int'(s_rx);
                cy = int'(s_ry);
                step();
                if (s_rst) begin aborted = 1'b1; break; end
                if (!s_lt[cy][cx]) begin placed = 1'b1; break; end
            end
            // sweep phase: starts at the cell after the last rejected sample
            if (!placed && !aborted) begin
                base = cy * 16 + cx + 1;
                for (int n = 0; n < 256; n++) begin
                    c = (base + n) % 256;
                    step();
                    if (s_rst) begin aborted = 1'b1; break; end
                    if (!s_lt[c / 16][c % 16]) begin
                        cx = c % 16;
                        cy = c / 16;
                        placed = 1'b1;
                        break;
                    end
                end
            end
            if (placed) begin
                m_valid = 1'b1;
                m_x     = cx;
                m_y     = cy;
                do step(); while (!s_rst && !s_e);
                if (s_rst) aborted = 1'b1;
                else m_valid = 1'b0;
            end else if (!aborted) begin
                m_full  = 1'b1;
                m_valid = 1'b0;
                do step(); while (!s_rst);
                aborted = 1'b1;
            end
            if (aborted) begin
                m_valid = 1'b0;
                m_full  = 1'b0;
                m_x     = 0;
                m_y     = 0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [15:0][15:0] exp_grid;

    always @(negedge clk) begin
        if (m_armed) begin
            exp_grid = '0;
            if (m_valid) exp_grid[m_y][m_x] = 1'b1;
            chk("model_apple",       256'(apple),       256'(exp_grid));
            chk("model_apple_x",     256'(apple_x),     256'(m_x));
            chk("model_apple_y",     256'(apple_y),     256'(m_y));
            chk("model_apple_valid", 256'(apple_valid), 256'(m_valid));
            chk("model_board_full",  256'(board_full),  256'(m_full));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin : stim
        reset  = 1'b1;
        eaten  = 1'b0;
        lights = '0;
        rand_x = 4'd3;
        rand_y = 4'd10;

        // first apple two edges after reset release
        tick(1);
        chk("rst_valid", 256'(apple_valid), 256'(0));
        chk("rst_apple", 256'(apple), 256'(0));
        chk("rst_full",  256'(board_full), 256'(0));
        reset = 1'b0;
        tick(1);
        chk("t1_valid_e1", 256'(apple_valid), 256'(0));
        tick(1);
        chk("t1_bit",   256'(apple[10][3]), 256'(1));
        chk("t1_ones",  256'($countones(apple)), 256'(1));
        chk("t1_x",     256'(apple_x), 256'(3));
        chk("t1_y",     256'(apple_y), 256'(10));
        chk("t1_valid", 256'(apple_valid), 256'(1));

        // eaten clears at once, a second pulse during search is ignored
        rand_x = 4'd7;
        rand_y = 4'd2;
        eaten  = 1'b1;
        tick(1);
        chk("t2_apple0", 256'(apple), 256'(0));
        chk("t2_valid0", 256'(apple_valid), 256'(0));
        chk("t2_xkeep",  256'(apple_x), 256'(3));
        tick(1);
        eaten = 1'b0;
        tick(1);
        chk("t2_bit",   256'(apple[2][7]), 256'(1));
        chk("t2_ones",  256'($countones(apple)), 256'(1));
        chk("t2_x",     256'(apple_x), 256'(7));
        chk("t2_y",     256'(apple_y), 256'(2));

        // 8 rejections of (5,5), then the sweep takes (6,5) at edge 17
        lights       = '0;
        lights[5][5] = 1'b1;
        rand_x       = 4'd5;
        rand_y       = 4'd5;
        do_reset();
        tick(16);
        chk("t3_valid_e16", 256'(apple_valid), 256'(0));
        tick(1);
        chk("t3_bit",   256'(apple[5][6]), 256'(1));
        chk("t3_x",     256'(apple_x), 256'(6));
        chk("t3_y",     256'(apple_y), 256'(5));
        chk("t3_valid", 256'(apple_valid), 256'(1));
        // same again after eaten: full budget of tries is available again
        eaten = 1'b1;
        tick(1);
        eaten = 1'b0;
        tick(16);
        chk("t3b_valid_e16", 256'(apple_valid), 256'(0));
        tick(1);
        chk("t3b_bit", 256'(apple[5][6]), 256'(1));

        // sweep wraps from (15,15) to (0,0)
        lights       = '1;
        lights[0][0] = 1'b0;
        rand_x       = 4'd15;
        rand_y       = 4'd15;
        do_reset();
        tick(16);
        chk("t4_valid_e16", 256'(apple_valid), 256'(0));
        tick(1);
        chk("t4_bit",   256'(apple[0][0]), 256'(1));
        chk("t4_ones",  256'($countones(apple)), 256'(1));
        chk("t4_x",     256'(apple_x), 256'(0));
        chk("t4_y",     256'(apple_y), 256'(0));
        chk("t4_valid", 256'(apple_valid), 256'(1));

        // full board after 2*8+256 edges, sticky through eaten
        lights = '1;
        rand_x = 4'd9;
        rand_y = 4'd1;
        do_reset();
        tick(271);
        chk("t5_full_e271", 256'(board_full), 256'(0));
        tick(1);
        chk("t5_full",  256'(board_full), 256'(1));
        chk("t5_apple", 256'(apple), 256'(0));
        chk("t5_valid", 256'(apple_valid), 256'(0));
        for (int i = 0; i < 3; i++) begin
            eaten = 1'b1;
            tick(1);
            eaten = 1'b0;
            tick(1);
        end
        chk("t5_full_hold", 256'(board_full), 256'(1));
        reset = 1'b1;
        tick(1);
        chk("t5_full_clr", 256'(board_full), 256'(0));

        // reset in the middle of a sweep, then normal placement resumes
        lights        = '1;
        lights[12][3] = 1'b0;
        rand_x        = 4'd0;
        rand_y        = 4'd0;
        reset         = 1'b0;
        tick(66);
        chk("t6_valid_mid", 256'(apple_valid), 256'(0));
        reset = 1'b1;
        tick(1);
        chk("t6_apple", 256'(apple), 256'(0));
        chk("t6_x",     256'(apple_x), 256'(0));
        chk("t6_y",     256'(apple_y), 256'(0));
        chk("t6_valid", 256'(apple_valid), 256'(0));
        chk("t6_full",  256'(board_full), 256'(0));
        lights = '0;
        rand_x = 4'd9;
        rand_y = 4'd4;
        reset  = 1'b0;
        tick(1);
        chk("t6_valid_e1", 256'(apple_valid), 256'(0));
        tick(1);
        chk("t6_bit",   256'(apple[4][9]), 256'(1));
        chk("t6_ax",    256'(apple_x), 256'(9));
        chk("t6_ay",    256'(apple_y), 256'(4));
        chk("t6_avld",  256'(apple_valid), 256'(1));

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
